// File: rtl/lfsr_rng.sv
// ----------------------------------------------------------------------------
// lfsr_rng
//   Maximal-length Fibonacci LFSR (XNOR feedback) with a bounded-value port.
//   The LFSR free-runs while 'run' is high and also steps whenever a request
//   is accepted or a draw is in progress. A request returns a uniform value in
//   [0, limit) by masking the state to the smallest 2^k-1 covering limit-1 and
//   rejecting out-of-range candidates. After MAX_TRIES rejections it folds the
//   last candidate into range and flags err.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   run        free-run enable (step every cycle)
//   seed_load  load 'seed' into the state (highest priority, aborts a draw)
//   seed       seed value; all-ones is mapped to zero
//   state      current LFSR state
//   req        request a bounded value (accepted when req & ready)
//   limit      exclusive upper bound, 0 = full range
//   ready      high while idle
//   valid      one-cycle pulse, value/err are good
//   value      bounded result, held until the next valid
//   err        fallback path was used (qualified by valid)
// ----------------------------------------------------------------------------
module lfsr_rng #(
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] SEED      = '0,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] value,
  output logic             err
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_rng: WIDTH must be in 3..16");
  end
  if (SEED == {WIDTH{1'b1}}) begin : g_bad_seed
    $error("lfsr_rng: SEED must not be the all-ones lockup state");
  end
  if (MAX_TRIES < 1) begin : g_bad_tries
    $error("lfsr_rng: MAX_TRIES must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Feedback taps, bit n-1 set for tap n of the maximal-length polynomial
  // --------------------------------------------------------------------------
  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]      TAPS_ALL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
  localparam int               TRY_W    = $clog2(MAX_TRIES) + 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  // Smallest 2^k-1 >= lim-1. lim=0 wraps to all-ones, lim=1 gives 0.
  function automatic logic [WIDTH-1:0] mask_of(input logic [WIDTH-1:0] lim);
    logic [WIDTH-1:0] m;
    m = lim - 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] mask_q;
  logic [TRY_W-1:0] tries;

  logic             fb;
  logic             step;
  logic [WIDTH-1:0] cand;
  logic             hit;

  // Reduction XNOR over the tapped bits: with XNOR feedback the all-zero
  // state is legal and all-ones is the lockup state.
  assign fb    = ~^(state & TAPS);
  assign ready = (fsm == IDLE);
  assign step  = run | (fsm == DRAW) | (req & ready);
  assign cand  = state & mask_q;
  assign hit   = (limit_q == '0) || (cand < limit_q);

  // --------------------------------------------------------------------------
  // LFSR state
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SEED;
    end else if (seed_load) begin
      state <= (seed == {WIDTH{1'b1}}) ? '0 : seed;
    end else if (step) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM with registered result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm     <= IDLE;
      limit_q <= '0;
      mask_q  <= '0;
      tries   <= '0;
      valid   <= 1'b0;
      value   <= '0;
      err     <= 1'b0;
    end else begin
      // NOTE: valid defaults low every cycle so it can only ever be a
      // single-cycle pulse; branches below raise it when a result lands.
      valid <= 1'b0;
      if (seed_load) begin
        // Reseeding abandons any draw; a coincident req is dropped.
        fsm <= IDLE;
      end else begin
        case (fsm)
          IDLE: begin
            if (req) begin
              limit_q <= limit;
              mask_q  <= mask_of(limit);
              tries   <= '0;
              fsm     <= DRAW;
            end
          end
          DRAW: begin
            if (hit) begin
              value <= cand;
              err   <= 1'b0;
              valid <= 1'b1;
              fsm   <= IDLE;
            end else if (tries == LAST_TRY) begin
              // cand < 2*limit_q here, so one subtraction lands in range.
              value <= cand - limit_q;
              err   <= 1'b1;
              valid <= 1'b1;
              fsm   <= IDLE;
            end else begin
              tries <= tries + 1'b1;
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rng.sv
// ----------------------------------------------------------------------------
// tb_lfsr_rng
//   Self-checking bench for lfsr_rng (WIDTH=6). A second instance with
//   MAX_TRIES=1 exercises the fallback path. Expected results come from a
//   transaction-level model: the state sequence is produced by the shift and
//   XNOR rule, and each request is resolved by scanning the next draws for
//   the first in-range masked candidate.
// ----------------------------------------------------------------------------
module tb_lfsr_rng;

  localparam int W  = 6;
  localparam int MT = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         run, seed_load, req;
  logic [W-1:0] seed, limit;
  logic [W-1:0] state, value;
  logic         ready, valid, err;

  logic         seed_load1, req1;
  logic [W-1:0] seed1, limit1;
  logic [W-1:0] state1, value1;
  logic         ready1, valid1, err1;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_rng #(.WIDTH(W), .SEED(6'h00), .MAX_TRIES(MT)) dut (
    .clk(clk), .reset(reset), .run(run), .seed_load(seed_load), .seed(seed),
    .state(state), .req(req), .limit(limit), .ready(ready), .valid(valid),
    .value(value), .err(err)
  );

  lfsr_rng #(.WIDTH(W), .SEED(6'h00), .MAX_TRIES(1)) dut1 (
    .clk(clk), .reset(reset), .run(1'b0), .seed_load(seed_load1), .seed(seed1),
    .state(state1), .req(req1), .limit(limit1), .ready(ready1), .valid(valid1),
    .value(value1), .err(err1)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    int b;
    b = 1 - (((s >> 5) ^ (s >> 4)) & 1);
    return W'(((int'(s) * 2) % 64) + b);
  endfunction

  function automatic int mask_for(input int lim);
    int m;
    if (lim == 0) return 63;
    m = 0;
    while (m < lim - 1) m = m * 2 + 1;
    return m;
  endfunction

  // Resolve one request issued with state s0 in the accept cycle.
  task automatic predict(input logic [W-1:0] s0, input int lim, input int tmax,
                         output int lat, output int val, output int e,
                         output logic [W-1:0] s_after);
    logic [W-1:0] s;
    int mk, c;
    bit done;
    s = s0; mk = mask_for(lim); done = 0;
    lat = 0; val = 0; e = 0; s_after = s0;
    for (int i = 1; i <= tmax; i++) begin
      if (!done) begin
        s = lfsr_next(s);
        c = int'(s) & mk;
        if (lim == 0 || c < lim) begin
          val = c; e = 0; lat = i + 1; done = 1; s_after = lfsr_next(s);
        end else if (i == tmax) begin
          val = c - lim; e = 1; lat = i + 1; done = 1; s_after = lfsr_next(s);
        end
      end
    end
  endtask

  task automatic load(input logic [W-1:0] s);
    seed_load = 1'b1; seed = s;
    tick();
    seed_load = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [W-1:0] exp_s, s_after;
    int lat, val, e, got_lat;

    reset = 1'b0; run = 1'b0; seed_load = 1'b0; seed = '0; req = 1'b0; limit = '0;
    seed_load1 = 1'b0; seed1 = '0; req1 = 1'b0; limit1 = '0;

    // Reset state
    #12;
    check("rst_state", state, 6'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_value", value, 6'h00);
    check("rst_err",   err,   1'b0);
    @(negedge clk); reset = 1'b1;
    tick();
    check("rst_ready", ready, 1'b1);
    check("rst_hold",  state, 6'h00);

    // Full-period sequence from 0 with run=1
    exp_s = 6'h00;
    run = 1'b1;
    for (int i = 1; i <= 63; i++) begin
      tick();
      exp_s = lfsr_next(exp_s);
      check("seq_state", state, exp_s);
      check("seq_no_lockup", (state == 6'h3F), 1'b0);
    end
    check("seq_period", state, 6'h00);
    run = 1'b0;

    // Lockup guard and hold
    load(6'h3F);
    check("lockup_load", state, 6'h00);
    load(6'h15);
    check("seed_load", state, 6'h15);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seed_hold", state, 6'h15);
    end

    // req coincident with seed_load is ignored
    seed_load = 1'b1; seed = 6'h0A; req = 1'b1; limit = 6'd10;
    tick();
    seed_load = 1'b0; req = 1'b0;
    check("sl_req_state", state, 6'h0A);
    check("sl_req_ready", ready, 1'b1);
    tick();
    check("sl_req_novalid", valid, 1'b0);

    // Bounded hit: state 0, limit 10
    load(6'h00);
    req = 1'b1; limit = 6'd10;
    tick();
    req = 1'b0; limit = 6'd2;
    check("hit_t1_state", state, 6'h01);
    check("hit_t1_valid", valid, 1'b0);
    check("hit_t1_ready", ready, 1'b0);
    tick();
    check("hit_valid", valid, 1'b1);
    check("hit_value", value, 6'd1);
    check("hit_err",   err,   1'b0);
    check("hit_ready", ready, 1'b1);
    tick();
    check("hit_pulse", valid, 1'b0);
    check("hit_value_hold", value, 6'd1);

    // Rejection: seed 15, limit 9 -> value 7 at T6
    load(6'd15);
    req = 1'b1; limit = 6'd9;
    tick();
    req = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      limit = W'($urandom);
      tick();
      check("rej_wait", valid, 1'b0);
    end
    tick();
    check("rej_valid", valid, 1'b1);
    check("rej_value", value, 6'd7);
    check("rej_err",   err,   1'b0);

    // Fallback with MAX_TRIES=1: seed 15, limit 9 -> value 6, err at T2
    seed_load1 = 1'b1; seed1 = 6'd15;
    tick();
    seed_load1 = 1'b0;
    req1 = 1'b1; limit1 = 6'd9;
    tick();
    req1 = 1'b0;
    check("fb_t1_valid", valid1, 1'b0);
    tick();
    check("fb_valid", valid1, 1'b1);
    check("fb_value", value1, 6'd6);
    check("fb_err",   err1,   1'b1);

    // limit=0: full state after one draw
    load(6'h2A);
    req = 1'b1; limit = 6'd0;
    tick();
    req = 1'b0;
    tick();
    check("lim0_valid", valid, 1'b1);
    check("lim0_value", value, lfsr_next(6'h2A));
    check("lim0_err",   err,   1'b0);

    // limit=1: always 0 at T2
    load(6'h2A);
    req = 1'b1; limit = 6'd1;
    tick();
    req = 1'b0;
    tick();
    check("lim1_valid", valid, 1'b1);
    check("lim1_value", value, 6'd0);

    // Back-to-back with req held high, limit=1: valid every 2 cycles
    req = 1'b1; limit = 6'd1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("b2b_valid", valid, ((k % 2) == 0) ? 1'b1 : 1'b0);
      if (k % 2 == 0) check("b2b_value", value, 6'd0);
    end
    req = 1'b0;

    // Abort by seed_load during DRAW
    load(6'd15);
    req = 1'b1; limit = 6'd9;
    tick();
    req = 1'b0;
    tick();
    seed_load = 1'b1; seed = 6'h21;
    tick();
    seed_load = 1'b0;
    check("abort_sl_state", state, 6'h21);
    check("abort_sl_ready", ready, 1'b1);
    check("abort_sl_valid", valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_sl_novalid", valid, 1'b0);
      check("abort_sl_hold", state, 6'h21);
    end

    // Abort by reset during DRAW
    load(6'd15);
    req = 1'b1; limit = 6'd9;
    tick();
    req = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    check("abort_rst_state", state, 6'h00);
    check("abort_rst_valid", valid, 1'b0);
    @(negedge clk); reset = 1'b1;
    tick();
    check("abort_rst_ready", ready, 1'b1);
    check("abort_rst_hold",  state, 6'h00);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_rst_novalid", valid, 1'b0);
    end

    // Randomized transactions against the model
    exp_s = W'($urandom_range(0, 62));
    load(exp_s);
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        seed = W'($urandom_range(0, 63));
        exp_s = (seed == 6'h3F) ? 6'h00 : seed;
        load(seed);
        check("rnd_seed", state, exp_s);
      end
      limit = W'($urandom_range(0, 63));
      predict(exp_s, int'(limit), MT, lat, val, e, s_after);
      req = 1'b1;
      tick();
      got_lat = 0;
      for (int k = 2; k <= MT + 3; k++) begin
        if (got_lat == 0) begin
          run   = 1'($urandom);
          req   = 1'($urandom);
          limit = W'($urandom);
          tick();
          if (valid) got_lat = k;
        end
      end
      run = 1'b0; req = 1'b0;
      check("rnd_latency", got_lat, lat);
      check("rnd_value", value, val);
      check("rnd_err",   err,   e);
      check("rnd_ready", ready, 1'b1);
      check("rnd_state", state, s_after);
      exp_s = s_after;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised maximal-length Fibonacci LFSR random source with XNOR feedback.
- Supports widths 3..16, runtime seed load, free-run or on-demand stepping, and a req/valid port that returns a uniform value in [0, limit) by rejection sampling.
- Feeds game/test logic that needs bounded random numbers, e.g. grid positions and delays.

Parameters:
- WIDTH, 6, LFSR state width; legal 3..16.
- SEED, 0, reset state; all-ones is illegal and must fail elaboration.
- MAX_TRIES, 8, maximum rejection draws per request before the fallback path is taken; legal value ≥1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- run  in  1  free-run enable; the LFSR steps every cycle while 1.
- seed_load  in  1  load seed into the state this cycle.
- seed  in  WIDTH  seed value.
- state  out  WIDTH  current LFSR state.
- req  in  1  request a bounded value.
- limit  in  WIDTH  exclusive upper bound; 0 means the full range.
- ready  out  1  high in IDLE; a request is accepted when req & ready.
- valid  out  1  one-cycle pulse; value is good.
- value  out  WIDTH  bounded result.
- err  out  1  qualified by valid; fallback path was used.

Behaviour:
- Feedback taps (1-indexed, XNOR): 3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4; 9:9,5; 10:10,7; 11:11,9; 12:12,6,4,1; 13:13,4,3,1; 14:14,5,3,1; 15:15,14; 16:16,15,13,4.
- Step rule: state <= {state[WIDTH-2:0], xnor(taps)}.
- Period is 2^WIDTH-1. The all-ones state is the lockup state and never occurs.
- Reset (reset=0, async):
  - state=SEED, FSM=IDLE, valid=0, value=0, err=0.
  - ready=1 once reset is released.
- Step enable: step = run | (FSM==DRAW) | (req & ready).
- seed_load has highest priority:
  - state <= seed; if seed is all-ones, state <= 0.
  - FSM is forced to IDLE; any draw in progress is aborted with no valid.
  - A req in the same cycle is ignored.
- FSM states IDLE and DRAW:
  - IDLE, on req & ready:
    - Capture limit_q=limit.
    - mask_q = smallest 2^k-1 ≥ limit-1 (mask_q=0 for limit=1; all-ones for limit=0).
    - Clear the try counter; go to DRAW. State also steps this cycle.
  - DRAW, every cycle:
    - cand = state & mask_q.
    - If limit_q==0, or cand < limit_q: register value=cand, err=0, valid=1 next cycle; go to IDLE.
    - Else, if tries == MAX_TRIES-1: register value=cand-limit_q (always < limit_q, since cand < 2*limit_q), err=1, valid=1; go to IDLE.
    - Else: tries++, stay in DRAW.
    - State steps every DRAW cycle.
- Latency:
  - Minimum: accept at T0, valid at T2.
  - Maximum: valid at T(MAX_TRIES+1).
- valid is high exactly one cycle, coinciding with ready=1.
- A req asserted in the same cycle as valid is accepted normally, allowing back-to-back requests.
- value and err hold until the next valid. err is only meaningful while valid=1.
- limit and run changes during DRAW have no effect on the draw in progress; run has no extra effect during DRAW because the state already steps every cycle.
- Try counter width is clog2(MAX_TRIES)+1 bits.

Test Plan:
- Sequence: WIDTH=6, SEED=0, run=1 after reset → state 0,1,3,7,15,31,62,…; returns to 0 after exactly 63 steps; state 63 never appears.
- Lockup guard: seed_load=1, seed=6'h3F → state=0 the next cycle. seed=6'h15 → state=6'h15, held while run=0 and req=0.
- Bounded hit: state=0, run=0, req with limit=10 at T0 → state=1 at T1, cand=1 accepted; at T2 valid=1, value=1, err=0, ready=1.
- Rejection: seed_load 15, then req with limit=9 → draws 31,62,61,59 rejected (cand 15,14,13,11), 55 accepted (cand 7); valid at T6 with value=7, err=0. With MAX_TRIES=1 → valid at T2 with value=6, err=1.
- Edge limits: limit=0 → value equals the full state after one draw. limit=1 → value=0 at T2, always. Back-to-back req held high → a valid every 2 cycles for limit=1.
- Aborts: reset=0 or seed_load during DRAW → no valid; FSM=IDLE; state=SEED or seed respectively; ready=1 the next cycle.
